// File: rtl/tx_arbiter_if.sv
// Bundle between the five source FIFOs, the host write FIFO and the tx arbiter.
// The master modport is the arbiter side; slave is the FIFO/host environment side.
interface tx_arbiter_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       src_en;
    logic [7:0]       in_din;
    logic             em_din;
    logic             pp_din;
    logic [11:0]      in_adc0;
    logic [11:0]      in_adc1;
    logic [11:0]      in_cadc0;
    logic [11:0]      in_cadc1;
    logic             em_adc0;
    logic             em_adc1;
    logic             em_cadc0;
    logic             em_cadc1;
    logic             pp_adc0;
    logic             pp_adc1;
    logic             pp_cadc0;
    logic             pp_cadc1;
    logic [7:0]       out_write;
    logic             ld_write;
    logic             fl_write;
    logic             busy;
    logic             stall;
    logic [CNT_W-1:0] pkt_cnt;

    modport master (
        input  src_en, in_din, em_din, in_adc0, in_adc1, in_cadc0, in_cadc1,
               em_adc0, em_adc1, em_cadc0, em_cadc1, fl_write,
        output pp_din, pp_adc0, pp_adc1, pp_cadc0, pp_cadc1,
               out_write, ld_write, busy, stall, pkt_cnt
    );

    modport slave (
        output src_en, in_din, em_din, in_adc0, in_adc1, in_cadc0, in_cadc1,
               em_adc0, em_adc1, em_cadc0, em_cadc1, fl_write,
        input  pp_din, pp_adc0, pp_adc1, pp_cadc0, pp_cadc1,
               out_write, ld_write, busy, stall, pkt_cnt
    );
endinterface

// File: rtl/tx_arbiter.sv
// Round-robin arbiter: pops one sample from a granted source queue and frames it
// into the write queue as a header byte plus one (DIN) or two (ADC/CADC) payload bytes.
module tx_arbiter #(
    parameter bit          SEQ_EN = 1'b1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    tx_arbiter_if.master  bus
);
    localparam int unsigned NSRC = 5;
    localparam int unsigned DW   = 12;
    localparam int unsigned TW   = 3;
    localparam int unsigned SW   = 5;
    localparam int unsigned IW   = 3;
    localparam logic [TW-1:0] TYPE_DIN = 3'b001;

    typedef enum logic [1:0] {IDLE, HDR, PAY_HI, PAY_LO} state_e;

    state_e           state_q, state_d;
    logic [IW-1:0]    last_q, last_d;
    logic [DW-1:0]    data_q, data_d;
    logic [TW-1:0]    type_q, type_d;
    logic [SW-1:0]    seq_q, seq_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NSRC-1:0]  pp_q, pp_d;
    logic [7:0]       out_q, out_d;
    logic             ld_q, ld_d;
    logic             busy_q, busy_d;
    logic             stall_q, stall_d;

    logic [NSRC-1:0]  elig_c;
    logic [DW-1:0]    src_data_c [NSRC];
    logic             gnt_vld_c;
    logic [IW-1:0]    gnt_idx_c;
    logic [SW-1:0]    hdr_seq_c;

    assign src_data_c[0] = DW'(bus.in_din);
    assign src_data_c[1] = bus.in_adc0;
    assign src_data_c[2] = bus.in_adc1;
    assign src_data_c[3] = bus.in_cadc0;
    assign src_data_c[4] = bus.in_cadc1;

    assign elig_c = bus.src_en & ~{bus.em_cadc1, bus.em_cadc0, bus.em_adc1,
                                   bus.em_adc0, bus.em_din};
    assign hdr_seq_c = SEQ_EN ? seq_q : '0;

    // First eligible source scanning last+1 .. last (wrapping), so last has lowest priority.
    always_comb begin
        gnt_vld_c = 1'b0;
        gnt_idx_c = last_q;
        for (int unsigned k = 1; k <= NSRC; k++) begin
            if (!gnt_vld_c && elig_c[IW'((32'(last_q) + k) % NSRC)]) begin
                gnt_vld_c = 1'b1;
                gnt_idx_c = IW'((32'(last_q) + k) % NSRC);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        data_d  = data_q;
        type_d  = type_q;
        seq_d   = seq_q;
        cnt_d   = cnt_q;
        pp_d    = '0;
        ld_d    = 1'b0;
        out_d   = out_q;
        stall_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_vld_c) begin
                    pp_d[gnt_idx_c] = 1'b1;
                    data_d          = src_data_c[gnt_idx_c];
                    type_d          = TW'(gnt_idx_c) + TW'(1);
                    last_d          = gnt_idx_c;
                    state_d         = HDR;
                end
            end
            HDR: begin
                if (!bus.fl_write) begin
                    ld_d    = 1'b1;
                    out_d   = {type_q, hdr_seq_c};
                    state_d = (type_q == TYPE_DIN) ? PAY_LO : PAY_HI;
                end else begin
                    stall_d = 1'b1;
                end
            end
            PAY_HI: begin
                if (!bus.fl_write) begin
                    ld_d    = 1'b1;
                    out_d   = {4'b0000, data_q[11:8]};
                    state_d = PAY_LO;
                end else begin
                    stall_d = 1'b1;
                end
            end
            PAY_LO: begin
                if (!bus.fl_write) begin
                    ld_d    = 1'b1;
                    out_d   = data_q[7:0];
                    seq_d   = seq_q + SW'(1);
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = IDLE;
                end else begin
                    stall_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Reset leaves last at CADC1 so DIN wins the first arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= IW'(4);
            data_q  <= '0;
            type_q  <= '0;
            seq_q   <= '0;
            cnt_q   <= '0;
            pp_q    <= '0;
            ld_q    <= 1'b0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            data_q  <= data_d;
            type_q  <= type_d;
            seq_q   <= seq_d;
            cnt_q   <= cnt_d;
            pp_q    <= pp_d;
            ld_q    <= ld_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            stall_q <= stall_d;
        end
    end

    assign bus.pp_din    = pp_q[0];
    assign bus.pp_adc0   = pp_q[1];
    assign bus.pp_adc1   = pp_q[2];
    assign bus.pp_cadc0  = pp_q[3];
    assign bus.pp_cadc1  = pp_q[4];
    assign bus.out_write = out_q;
    assign bus.ld_write  = ld_q;
    assign bus.busy      = busy_q;
    assign bus.stall     = stall_q;
    assign bus.pkt_cnt   = cnt_q;
endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: FWFT source FIFO models, write-byte monitor,
// and one task per scenario with hand-computed expected bytes.
module tb_tx_arbiter;
    logic clk;
    logic rst_n;

    tx_arbiter_if #(.CNT_W(16)) bus ();

    tx_arbiter #(.SEQ_EN(1'b1), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Source FIFO model: words loaded by the tasks, consumed on pp at posedge.
    int loaded [5];
    int popped [5];
    int underflow = 0;
    logic [4:0] pp_v;
    assign pp_v = {bus.pp_cadc1, bus.pp_cadc0, bus.pp_adc1, bus.pp_adc0, bus.pp_din};
    assign bus.em_din   = (loaded[0] <= popped[0]);
    assign bus.em_adc0  = (loaded[1] <= popped[1]);
    assign bus.em_adc1  = (loaded[2] <= popped[2]);
    assign bus.em_cadc0 = (loaded[3] <= popped[3]);
    assign bus.em_cadc1 = (loaded[4] <= popped[4]);

    always @(posedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (pp_v[i]) begin
                if (loaded[i] <= popped[i]) underflow <= underflow + 1;
                popped[i] <= popped[i] + 1;
            end
        end
    end

    // Output monitor, sampled on the falling edge.
    logic [7:0] bytes [$];
    int ld_cyc [$];
    int cyc = 0;
    int stall_cnt = 0;
    int busy_cnt = 0;
    int mon_pops [5];
    int run [5];
    int max_run [5];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.ld_write) begin
            bytes.push_back(bus.out_write);
            ld_cyc.push_back(cyc);
        end
        if (bus.stall) stall_cnt = stall_cnt + 1;
        if (bus.busy) busy_cnt = busy_cnt + 1;
        for (int i = 0; i < 5; i++) begin
            if (pp_v[i]) begin
                mon_pops[i] = mon_pops[i] + 1;
                run[i] = run[i] + 1;
                if (run[i] > max_run[i]) max_run[i] = run[i];
            end else begin
                run[i] = 0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if (pp_v !== 5'b0 || bus.ld_write !== 1'b0 || bus.out_write !== 8'h00 ||
            bus.busy !== 1'b0 || bus.stall !== 1'b0 || bus.pkt_cnt !== 16'd0) begin
            errors++;
            $display("FAIL %s: pp=%b ld=%b out=%h busy=%b stall=%b cnt=%0d, required all zero",
                     tag, pp_v, bus.ld_write, bus.out_write, bus.busy, bus.stall, bus.pkt_cnt);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.fl_write = 1'b0;
        bus.src_en = 5'b0;
        bus.in_din = 8'h00;
        bus.in_adc0 = 12'h000;
        bus.in_adc1 = 12'h000;
        bus.in_cadc0 = 12'h000;
        bus.in_cadc1 = 12'h000;
        step(3);
        check_idle_outputs("reset_state");
        rst_n = 1'b1;
        step(2);
        check_idle_outputs("after_release");
    endtask

    task automatic test_din_single();
        int base;
        int p0;
        base = bytes.size();
        p0 = mon_pops[0];
        bus.src_en = 5'b00001;
        bus.in_din = 8'hA5;
        loaded[0]++;
        step(12);
        checks++;
        if (bytes.size() - base !== 2) begin
            errors++;
            $display("FAIL din_bytes: got %0d bytes, required 2", bytes.size() - base);
        end else begin
            checks++;
            if (bytes[base] !== 8'h20 || bytes[base+1] !== 8'hA5) begin
                errors++;
                $display("FAIL din_data: got %h %h, required 20 a5", bytes[base], bytes[base+1]);
            end
        end
        checks++;
        if (mon_pops[0] - p0 !== 1) begin
            errors++;
            $display("FAIL din_pops: got %0d, required 1", mon_pops[0] - p0);
        end
        checks++;
        if (bus.pkt_cnt !== 16'd1) begin
            errors++;
            $display("FAIL din_pkt_cnt: got %0d, required 1", bus.pkt_cnt);
        end
    endtask

    task automatic test_adc0_single();
        int base;
        logic [7:0] exp_b [3];
        exp_b = '{8'h41, 8'h03, 8'hC7};
        base = bytes.size();
        bus.src_en = 5'b11111;
        bus.in_adc0 = 12'h3C7;
        loaded[1]++;
        step(12);
        checks++;
        if (bytes.size() - base !== 3) begin
            errors++;
            $display("FAIL adc0_bytes: got %0d bytes, required 3", bytes.size() - base);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (bytes[base+i] !== exp_b[i]) begin
                    errors++;
                    $display("FAIL adc0_byte%0d: got %h, required %h", i, bytes[base+i], exp_b[i]);
                end
            end
        end
        checks++;
        if (max_run[1] !== 1) begin
            errors++;
            $display("FAIL adc0_pop_width: got %0d cycles, required 1", max_run[1]);
        end
        checks++;
        if (bus.pkt_cnt !== 16'd2) begin
            errors++;
            $display("FAIL adc0_pkt_cnt: got %0d, required 2", bus.pkt_cnt);
        end
    endtask

    task automatic test_round_robin();
        int base;
        logic [7:0] exp_b [16];
        exp_b = '{8'h20, 8'h11, 8'h41, 8'h01, 8'h23, 8'h62, 8'h04, 8'h56,
                  8'h83, 8'h07, 8'h89, 8'hA4, 8'h0A, 8'hBC, 8'h25, 8'h11};
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        base = bytes.size();
        bus.in_din = 8'h11;
        bus.in_adc0 = 12'h123;
        bus.in_adc1 = 12'h456;
        bus.in_cadc0 = 12'h789;
        bus.in_cadc1 = 12'hABC;
        loaded[0] += 2;
        for (int i = 1; i < 5; i++) loaded[i]++;
        bus.src_en = 5'b11111;
        step(40);
        checks++;
        if (bytes.size() - base !== 16) begin
            errors++;
            $display("FAIL rr_bytes: got %0d bytes, required 16", bytes.size() - base);
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (bytes[base+i] !== exp_b[i]) begin
                    errors++;
                    $display("FAIL rr_byte%0d: got %h, required %h", i, bytes[base+i], exp_b[i]);
                end
            end
            checks++;
            if (ld_cyc[base+2] - ld_cyc[base+1] !== 2) begin
                errors++;
                $display("FAIL rr_gap: got %0d cycles between packets, required 2",
                         ld_cyc[base+2] - ld_cyc[base+1]);
            end
        end
        checks++;
        if (bus.pkt_cnt !== 16'd6) begin
            errors++;
            $display("FAIL rr_pkt_cnt: got %0d, required 6", bus.pkt_cnt);
        end
    endtask

    task automatic test_stall();
        int base;
        int s0;
        int n;
        logic [7:0] exp_b [3];
        exp_b = '{8'h66, 8'h04, 8'h56};
        base = bytes.size();
        s0 = stall_cnt;
        bus.src_en = 5'b00100;
        loaded[2]++;
        n = 0;
        while (bus.ld_write !== 1'b1 && n < 20) begin
            step(1);
            n++;
        end
        checks++;
        if (bus.ld_write !== 1'b1) begin
            errors++;
            $display("FAIL stall_header_timeout: ld_write=%b, required 1", bus.ld_write);
        end
        bus.fl_write = 1'b1;
        step(3);
        checks++;
        if (bus.stall !== 1'b1 || bus.ld_write !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_mid: stall=%b ld=%b busy=%b, required 1 0 1",
                     bus.stall, bus.ld_write, bus.busy);
        end
        step(2);
        bus.fl_write = 1'b0;
        step(10);
        checks++;
        if (stall_cnt - s0 !== 5) begin
            errors++;
            $display("FAIL stall_cycles: got %0d, required 5", stall_cnt - s0);
        end
        checks++;
        if (bytes.size() - base !== 3) begin
            errors++;
            $display("FAIL stall_bytes: got %0d bytes, required 3", bytes.size() - base);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (bytes[base+i] !== exp_b[i]) begin
                    errors++;
                    $display("FAIL stall_byte%0d: got %h, required %h", i, bytes[base+i], exp_b[i]);
                end
            end
            checks++;
            if (ld_cyc[base+1] - ld_cyc[base] !== 6) begin
                errors++;
                $display("FAIL stall_hdr_to_pay: got %0d cycles, required 6",
                         ld_cyc[base+1] - ld_cyc[base]);
            end
        end
    endtask

    task automatic test_disabled();
        int base;
        int b0;
        int p_sum0;
        int p_sum1;
        base = bytes.size();
        b0 = busy_cnt;
        p_sum0 = 0;
        for (int i = 0; i < 5; i++) p_sum0 += mon_pops[i];
        bus.src_en = 5'b00000;
        for (int i = 0; i < 5; i++) loaded[i] += 3;
        step(10);
        p_sum1 = 0;
        for (int i = 0; i < 5; i++) p_sum1 += mon_pops[i];
        checks++;
        if (p_sum1 - p_sum0 !== 0 || bytes.size() - base !== 0 || busy_cnt - b0 !== 0) begin
            errors++;
            $display("FAIL disabled: pops=%0d bytes=%0d busy_cycles=%0d, required 0 0 0",
                     p_sum1 - p_sum0, bytes.size() - base, busy_cnt - b0);
        end
    endtask

    task automatic test_reset_mid_packet();
        int base;
        int n;
        logic [7:0] exp_b [5];
        exp_b = '{8'h20, 8'h11, 8'h81, 8'h07, 8'h89};
        bus.src_en = 5'b01000;
        n = 0;
        while (bus.ld_write !== 1'b1 && n < 20) begin
            step(1);
            n++;
        end
        checks++;
        if (bus.ld_write !== 1'b1 || bus.out_write !== 8'h87) begin
            errors++;
            $display("FAIL cadc0_header: ld=%b out=%h, required 1 87", bus.ld_write, bus.out_write);
        end
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_packet_reset");
        step(2);
        base = bytes.size();
        bus.src_en = 5'b01001;
        rst_n = 1'b1;
        step(16);
        bus.src_en = 5'b00000;
        checks++;
        if (bytes.size() - base < 5) begin
            errors++;
            $display("FAIL post_reset_bytes: got %0d bytes, required at least 5", bytes.size() - base);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (bytes[base+i] !== exp_b[i]) begin
                    errors++;
                    $display("FAIL post_reset_byte%0d: got %h, required %h", i, bytes[base+i], exp_b[i]);
                end
            end
        end
        step(10);
        checks++;
        if (underflow !== 0) begin
            errors++;
            $display("FAIL pop_of_empty: got %0d pops of empty queues, required 0", underflow);
        end
    endtask

    initial begin
        for (int i = 0; i < 5; i++) begin
            loaded[i] = 0;
            popped[i] = 0;
            mon_pops[i] = 0;
            run[i] = 0;
            max_run[i] = 0;
        end
        test_reset();
        test_din_single();
        test_adc0_single();
        test_round_robin();
        test_stall();
        test_disabled();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
